// File: rtl/mem_stage_access.sv
// MEM-stage data-memory initiator: drives the dcache request, formats the load/store data and stalls the pipeline.
// Latency: request is combinational off EX/MEM; load data passes through on the resp cycle and is latched afterwards.
// Backpressure: stall_o holds all pipeline registers until dmem_resp; DONE state blocks reissue while advance_i is low.
module mem_stage_access #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic        advance_i,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        timeout_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {
    S_ACCESS = 1'b0,
    S_DONE   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   latch_q, latch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    off;
  logic          mem_op;
  logic          pend;
  logic          req;
  logic          resp_acc;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   fmt_data;

  assign off    = addr_i[1:0];
  assign mem_op = valid_i & (mem_read_i | mem_write_i);

  // Alignment check: halves need an even address, words a word-aligned one.
  always_comb begin
    misaligned_o = 1'b0;
    if (mem_op) begin
      case (funct3_i[1:0])
        2'b01:   misaligned_o = addr_i[0];
        2'b10:   misaligned_o = (off != 2'b00);
        default: misaligned_o = 1'b0;
      endcase
    end
  end

  assign pend = mem_op & ~misaligned_o;

  // Address, shifted store data and byte enables.
  always_comb begin
    dmem_address = {addr_i[31:2], 2'b00};
    dmem_wdata   = store_data_i << {off, 3'b000};
    case (funct3_i[1:0])
      2'b00:   dmem_mbe = 4'b0001 << off;
      2'b01:   dmem_mbe = 4'b0011 << off;
      default: dmem_mbe = 4'b1111;
    endcase
  end

  // Load extraction: pick the addressed byte/half and sign- or zero-extend.
  always_comb begin
    case (off)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = addr_i[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_i)
      3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  fmt_data = {24'h0, byte_sel};
      3'b101:  fmt_data = {16'h0, half_sel};
      default: fmt_data = dmem_rdata;
    endcase
  end

  // State register: DONE remembers that the held instruction was already served.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ACCESS;
    else     state_q <= state_d;
  end

  // Next state: finish without advance parks in DONE until the pipeline moves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCESS: if (resp_acc && !advance_i) state_d = S_DONE;
      S_DONE:   if (advance_i)              state_d = S_ACCESS;
      default:  state_d = S_ACCESS;
    endcase
  end

  // Outputs: requests only from ACCESS, all forced quiet while in reset.
  always_comb begin
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    req        = 1'b0;
    if (!rst && state_q == S_ACCESS) begin
      dmem_read  = pend & mem_read_i;
      dmem_write = pend & mem_write_i;
      req        = pend;
    end
    resp_acc    = req & dmem_resp;
    stall_o     = req & ~dmem_resp;
    load_data_o = resp_acc ? fmt_data : latch_q;
  end

  // Load latch and wait counter next-state; a stray resp with no request is ignored.
  always_comb begin
    latch_d   = resp_acc ? fmt_data : latch_q;
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (req && !dmem_resp) begin
      cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
      if (TIMEOUT != 0 && cnt_d == TMAX) timeout_d = 1'b1;
    end
  end

  // Datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: directed scenarios then random traffic against a behavioural model.
// Model tracks whether the held instruction was already served, the latched load value and wait time.
// Inputs change 1 ns after the rising edge; outputs are compared 3 ns later, away from any edge.
module tb_mem_stage_access;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, valid_i, mem_read_i, mem_write_i, advance_i, dmem_resp;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i, dmem_rdata;
  logic        dmem_read, dmem_write, stall_o, misaligned_o, timeout_o;
  logic [31:0] dmem_address, dmem_wdata, load_data_o;
  logic [3:0]  dmem_mbe;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_served = 0;
  logic [31:0] m_latch  = '0;
  int          m_wait   = 0;
  bit          m_tmo    = 0;
  bit          e_req;
  logic [31:0] e_fmt;

  always #5 clk = ~clk;

  mem_stage_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .advance_i(advance_i), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .load_data_o(load_data_o), .stall_o(stall_o), .misaligned_o(misaligned_o),
    .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint v;
    int unsigned o = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * o)) % 256;
        if (f3 == 3'd0 && v >= 128) v -= 256;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * (o / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
      end
      default: v = rd;
    endcase
    return v[31:0];
  endfunction

  task automatic apply(input logic r, input logic v, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                       input logic adv, input logic rsp, input logic [31:0] rdat);
    rst = r; valid_i = v; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    addr_i = a; store_data_i = sd; advance_i = adv; dmem_resp = rsp; dmem_rdata = rdat;
    #3;
  endtask

  // Compare every output against the model for the inputs currently applied.
  task automatic check_model();
    int  sz = (funct3_i % 4 == 0) ? 1 : (funct3_i % 4 == 1) ? 2 : 4;
    bit  memop = valid_i && (mem_read_i || mem_write_i);
    bit  mis = memop && (addr_i % sz != 0);
    int  o = addr_i % 4;
    logic [31:0] mbe;
    e_req = !rst && memop && !mis && !m_served;
    e_fmt = ref_load(funct3_i, addr_i, dmem_rdata);
    mbe   = (sz == 4) ? 32'd15 : (sz == 2) ? (32'd3 << o) : (32'd1 << o);
    chk("misaligned", {31'b0, misaligned_o}, {31'b0, mis});
    chk("dmem_read",  {31'b0, dmem_read},  {31'b0, e_req && mem_read_i});
    chk("dmem_write", {31'b0, dmem_write}, {31'b0, e_req && mem_write_i});
    chk("stall",      {31'b0, stall_o},    {31'b0, e_req && !dmem_resp});
    chk("timeout",    {31'b0, timeout_o},  {31'b0, m_tmo});
    chk("load_data",  load_data_o, (e_req && dmem_resp) ? e_fmt : m_latch);
    if (e_req) begin
      chk("address", dmem_address, addr_i - o);
      if (mem_write_i) begin
        chk("mbe",   {28'b0, dmem_mbe}, mbe);
        chk("wdata", dmem_wdata, store_data_i << (8 * o));
      end
    end
  endtask

  // Advance the model by one clock and move to the next drive point.
  task automatic tick();
    if (rst) begin
      m_served = 0; m_latch = '0; m_wait = 0; m_tmo = 0;
    end else begin
      if (e_req && dmem_resp) begin
        m_latch  = e_fmt;
        m_served = !advance_i;
      end else if (m_served && advance_i) begin
        m_served = 0;
      end
      if (e_req && !dmem_resp) begin
        if (m_wait < TMO) m_wait++;
        if (m_wait == TMO) m_tmo = 1;
      end else begin
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a live store presented: nothing may be requested
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      check_model();
      chk("rst_write", {31'b0, dmem_write}, 32'd0);
      tick();
    end

    // SW 0x100, response after three waiting cycles
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0);
      check_model();
      chk("sw_wait_write", {31'b0, dmem_write}, 32'd1);
      tick();
    end
    apply(0, 1, 0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 1, 1, 0);
    check_model();
    chk("sw_mbe", {28'b0, dmem_mbe}, 32'hF);
    chk("sw_resp_stall", {31'b0, stall_o}, 32'd0);
    tick();

    // LB / LBU at 0x103
    apply(0, 1, 1, 0, 3'd0, 32'h103, 0, 1, 1, 32'h80FF0000);
    check_model();
    chk("lb_const", load_data_o, 32'hFFFFFF80);
    tick();
    apply(0, 1, 1, 0, 3'd4, 32'h103, 0, 1, 1, 32'h80FF0000);
    check_model();
    chk("lbu_const", load_data_o, 32'h00000080);
    tick();

    // SH 0x102
    apply(0, 1, 0, 1, 3'd1, 32'h102, 32'h00001234, 1, 1, 0);
    check_model();
    chk("sh_wdata", dmem_wdata, 32'h12340000);
    chk("sh_mbe", {28'b0, dmem_mbe}, 32'hC);
    chk("sh_addr", dmem_address, 32'h100);
    tick();

    // LW finishing while the pipeline is held: single request, data held
    apply(0, 1, 1, 0, 3'd2, 32'h200, 0, 0, 1, 32'h11223344);
    check_model();
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 1, 0, 3'd2, 32'h200, 0, 0, 1'($urandom_range(0, 1)), $urandom);
      check_model();
      chk("done_no_read", {31'b0, dmem_read}, 32'd0);
      chk("done_held", load_data_o, 32'h11223344);
      tick();
    end
    apply(0, 1, 1, 0, 3'd2, 32'h200, 0, 1, 0, 0);
    check_model();
    tick();
    apply(0, 1, 1, 0, 3'd2, 32'h204, 0, 0, 0, 0);
    check_model();
    chk("back_to_access", {31'b0, dmem_read}, 32'd1);
    tick();
    apply(0, 1, 1, 0, 3'd2, 32'h204, 0, 1, 1, 32'h5);
    check_model();
    tick();

    // misaligned word load
    apply(0, 1, 1, 0, 3'd2, 32'h101, 0, 1, 0, 0);
    check_model();
    chk("mis_flag", {31'b0, misaligned_o}, 32'd1);
    chk("mis_stall", {31'b0, stall_o}, 32'd0);
    tick();

    // timeout: request never answered
    for (int i = 0; i < TMO; i++) begin
      apply(0, 1, 1, 0, 3'd2, 32'h300, 0, 0, 0, 0);
      check_model();
      chk("tmo_clear", {31'b0, timeout_o}, 32'd0);
      tick();
    end
    apply(0, 1, 1, 0, 3'd2, 32'h300, 0, 0, 0, 0);
    check_model();
    chk("tmo_set", {31'b0, timeout_o}, 32'd1);
    chk("tmo_still_req", {31'b0, dmem_read}, 32'd1);
    tick();
    apply(1, 1, 1, 0, 3'd2, 32'h300, 0, 0, 0, 0);
    check_model();
    chk("rst_read", {31'b0, dmem_read}, 32'd0);
    tick();
    apply(0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0);
    check_model();
    chk("rst_tmo", {31'b0, timeout_o}, 32'd0);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f3;
      logic       ld;
      ld = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = ld ? 3'd4 : 3'd0;
        default: f3 = ld ? 3'd5 : 3'd1;
      endcase
      apply(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
            ld, ~ld & 1'($urandom_range(0, 5) != 0), f3, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom);
      check_model();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
